okdram_fifo_ctrl: RTL and testbench

Synchronous 64-entry × 8-bit FIFO controller that sequences one okDRAM64X8D distributed-RAM instance. It owns write/read pointers, occupancy, flags and a registered read-data stage. It sits between a byte-stream producer and consumer in the same clock domain, for example pixel-byte staging ahead of a pipe-out. Rejected accesses are reported through sticky error flags; they never corrupt state.

---
 rtl/okdram_fifo_pkg.sv | 10 +
 rtl/okdram_fifo_ctrl_ram.sv | 20 ++
 rtl/okdram_fifo_ctrl.sv | 79 +++++++
 tb/tb_okdram_fifo_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/okdram_fifo_pkg.sv
// Shared constants and types for the okDRAM64X8D-backed byte FIFO.
package okdram_fifo_pkg;
  localparam int FIFO_DEPTH = 64;
  localparam int FIFO_AW    = 6;
  localparam int FIFO_DW    = 8;
  localparam int PTR_W      = 7;
  localparam int CNT_W      = 7;

  typedef logic [PTR_W-1:0] fifo_ptr_t;
endpackage

// File: rtl/okdram_fifo_ctrl_ram.sv
// 64x8 dual-port distributed RAM: synchronous write on port A, asynchronous reads on A and B.
module okDRAM64X8D
  import okdram_fifo_pkg::*;
(
  input  logic               wclk,
  input  logic               we,
  input  logic [FIFO_AW-1:0] addrA,
  input  logic [FIFO_AW-1:0] addrB,
  input  logic [FIFO_DW-1:0] din,
  output logic [FIFO_DW-1:0] doutA,
  output logic [FIFO_DW-1:0] doutB
);
  logic [FIFO_DW-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge wclk)
    if (we) mem[addrA] <= din;

  assign doutA = mem[addrA];
  assign doutB = mem[addrB];
endmodule

// File: rtl/okdram_fifo_ctrl.sv
// Single-clock 64x8 FIFO controller: pointers, occupancy, registered flags and read-data stage
// around one okDRAM64X8D instance.
module okdram_fifo_ctrl
  import okdram_fifo_pkg::*;
#(
  parameter int AFULL_THRESH  = 48,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [FIFO_DW-1:0] wr_data,
  input  logic               rd_en,
  output logic [FIFO_DW-1:0] rd_data,
  output logic               rd_valid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  output logic               underflow
);
  fifo_ptr_t          wr_ptr, rd_ptr;
  logic               wr_acc, rd_acc;
  logic [CNT_W-1:0]   count_nxt;
  logic [FIFO_DW-1:0] ram_doutb;

  // Requests are qualified only by registered flags, never by the other port.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CNT_W'(1);
    else if (rd_acc && !wr_acc) count_nxt = count - CNT_W'(1);
  end

  okDRAM64X8D u_ram (
    .wclk  (clk),
    .we    (wr_acc),
    .addrA (wr_ptr[FIFO_AW-1:0]),
    .addrB (rd_ptr[FIFO_AW-1:0]),
    .din   (wr_data),
    .doutA (),
    .doutB (ram_doutb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_data <= ram_doutb;
      end
      rd_valid     <= rd_acc;
      count        <= count_nxt;
      // Flags track next-state count so they never lag the occupancy output.
      full         <= (count_nxt == CNT_W'(FIFO_DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CNT_W'(AFULL_THRESH));
      almost_empty <= (count_nxt <= CNT_W'(AEMPTY_THRESH));
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_okdram_fifo_ctrl.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_okdram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [6:0] count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // reference model state
  byte unsigned q[$];
  logic [7:0] m_rd_data = '0;
  logic       m_rd_valid = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  okdram_fifo_ctrl #(.AFULL_THRESH(48), .AEMPTY_THRESH(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit w, input logic [7:0] wd, input bit r, input bit rst);
    bit f, e;
    if (rst) begin
      q.delete();
      m_rd_data = '0; m_rd_valid = 0; m_ovf = 0; m_unf = 0;
    end else begin
      f = (q.size() == 64);
      e = (q.size() == 0);
      if (w && f) m_ovf = 1;
      if (r && e) m_unf = 1;
      m_rd_valid = r && !e;
      if (r && !e) m_rd_data = q.pop_front();
      if (w && !f) q.push_back(wd);
    end
  endtask

  // one clock: drive on negedge, advance model at posedge, settle just after
  task automatic cyc(input bit w, input logic [7:0] wd, input bit r, input bit rst);
    @(negedge clk);
    wr_en = w; wr_data = wd; rd_en = r; reset = rst;
    @(posedge clk);
    model_step(w, wd, r, rst);
    #1;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [21:0] act, exp;
      int n;
      n = q.size();
      act = {rd_data, rd_valid, count, full, empty, almost_full, almost_empty, overflow, underflow};
      exp = {m_rd_data, m_rd_valid, 7'(n), n == 64, n == 0, n >= 48, n <= 8, m_ovf, m_unf};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t: {rd_data,vld,cnt,f,e,af,ae,ovf,unf} got %0h expected %0h",
                 $time, act, exp);
      end
    end
  end

  initial begin
    int wcnt;
    // reset with arbitrary inputs
    cyc(1'($urandom), 8'($urandom), 1'($urandom), 1);
    chk_en = 1;
    chk("reset_state", {rd_data, rd_valid, count, full, empty, almost_full, almost_empty, overflow, underflow},
        {8'h00, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

    // fill 0x00..0x3F
    for (int i = 0; i < 64; i++) begin
      cyc(1, 8'(i), 0, 0);
      if (i == 46) chk("af_below_48", almost_full, 1'b0);
      if (i == 47) chk("af_at_48", almost_full, 1'b1);
    end
    chk("fill_count", count, 7'd64);
    chk("fill_full", full, 1'b1);

    // overflow at full
    cyc(1, 8'hAA, 0, 0);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_count", count, 7'd64);

    // drain, rd_valid continuous
    for (int i = 0; i < 64; i++) begin
      cyc(0, 8'h00, 1, 0);
      chk("drain_data", rd_data, 8'(i));
      chk("drain_vld", rd_valid, 1'b1);
    end
    cyc(0, 8'h00, 0, 0);
    chk("drain_empty", empty, 1'b1);
    chk("drain_hold", rd_data, 8'h3F);

    // underflow with simultaneous write
    cyc(1, 8'h5A, 1, 0);
    chk("unf_flag", underflow, 1'b1);
    chk("unf_count", count, 7'd1);
    chk("unf_novld", rd_valid, 1'b0);
    cyc(0, 8'h00, 1, 0);
    chk("unf_readback", {rd_valid, rd_data}, {1'b1, 8'h5A});

    // half-full wrap streaming
    wcnt = 0;
    for (int i = 0; i < 32; i++) begin cyc(1, 8'(wcnt), 0, 0); wcnt++; end
    for (int i = 0; i < 300; i++) begin
      cyc(1, 8'(wcnt), 1, 0); wcnt++;
      if (i == 0) chk("stream_first", rd_data, 8'h00);
    end
    chk("stream_count", count, 7'd32);
    chk("stream_last", rd_data, 8'(299));

    // mid-operation reset at count 20
    for (int i = 0; i < 12; i++) cyc(0, 8'h00, 1, 0);
    chk("pre_rst_count", count, 7'd20);
    cyc(1, 8'hEE, 1, 1);
    chk("rst_mid", {count, empty, rd_valid, overflow, underflow}, {7'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    cyc(1, 8'h11, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("rst_readback", {rd_valid, rd_data}, {1'b1, 8'h11});

    // randomized phases biased toward fill, drain and balanced traffic
    for (int ph = 0; ph < 12; ph++) begin
      int pw, pr;
      case (ph % 3)
        0: begin pw = 85; pr = 30; end
        1: begin pw = 30; pr = 85; end
        default: begin pw = 60; pr = 60; end
      endcase
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
            $urandom_range(299) == 0);
    end

    cyc(0, 8'h00, 0, 0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
